// File: rtl/sprite_write_sched.sv
`default_nettype none
// ============================================================================
// Module  : sprite_write_sched
// Brief   : Buffers CPU sprite-position writes and replays them to the graphics
//           RAM unit over a wrn-strobed bus, optionally only during vblank.
// Revision: 1.0
// ============================================================================
module sprite_write_sched #(
    parameter int DEPTH       = 8,
    parameter int PTR_W       = 3,
    parameter int VBLANK_GATE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_we,
    input  logic [7:0]       cpu_id,
    input  logic [9:0]       cpu_data,
    output logic             cpu_ready,
    output logic             ovf,
    input  logic             ovf_clr,
    output logic [PTR_W:0]   pending,
    input  logic             vblank,
    output logic [7:0]       sprite_id,
    output logic [9:0]       sprite_x,
    output logic [8:0]       sprite_y,
    output logic             wrn
);

    localparam logic [PTR_W:0] c_DEPTH = (PTR_W + 1)'(DEPTH);
    localparam logic           c_GATE  = (VBLANK_GATE != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_LOW   = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [17:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [PTR_W:0]     r_count;
    logic               r_ovf;
    logic               r_wrn;
    logic [7:0]         r_id;
    logic [9:0]         r_x;
    logic [8:0]         r_y;

    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic [17:0]        w_head;

    assign w_full = (r_count == c_DEPTH);
    assign w_push = cpu_we && !w_full;
    assign w_pop  = (r_state == S_IDLE) && (r_count != '0) && (vblank || !c_GATE);
    assign w_head = r_mem[r_rptr];

    // Storage carries no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {cpu_id, cpu_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (ovf_clr) begin
                r_ovf <= 1'b0;
            end else if (cpu_we && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_pop) w_next = S_SETUP;
            S_SETUP: w_next = S_LOW;
            S_LOW:   w_next = S_HOLD;
            S_HOLD:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wrn   <= 1'b1;
        end else begin
            r_state <= w_next;
            r_wrn   <= (w_next != S_LOW);
        end
    end

    // A reset landing mid-strobe forces wrn high; keep the bus data so that
    // forced rising edge still writes the intended entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (r_state != S_LOW) begin
                r_id <= '0;
                r_x  <= '0;
                r_y  <= '0;
            end
        end else if (w_pop) begin
            r_id <= w_head[17:10];
            r_x  <= w_head[9:0];
            r_y  <= w_head[8:0];
        end
    end

    assign cpu_ready = !w_full;
    assign pending   = r_count;
    assign ovf       = r_ovf;
    assign wrn       = r_wrn;
    assign sprite_id = r_id;
    assign sprite_x  = r_x;
    assign sprite_y  = r_y;

endmodule
`default_nettype wire

// File: tb/tb_sprite_write_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_sprite_write_sched
// Brief   : Scoreboard bench for sprite_write_sched; directed vectors.
// Revision: 1.0
// ============================================================================
module tb_sprite_write_sched;

    logic       clk;
    logic       rst;
    logic       cpu_we;
    logic [7:0] cpu_id;
    logic [9:0] cpu_data;
    logic       cpu_ready;
    logic       ovf;
    logic       ovf_clr;
    logic [3:0] pending;
    logic       vblank;
    logic [7:0] sprite_id;
    logic [9:0] sprite_x;
    logic [8:0] sprite_y;
    logic       wrn;

    sprite_write_sched #(.DEPTH(8), .PTR_W(3), .VBLANK_GATE(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_we    (cpu_we),
        .cpu_id    (cpu_id),
        .cpu_data  (cpu_data),
        .cpu_ready (cpu_ready),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .pending   (pending),
        .vblank    (vblank),
        .sprite_id (sprite_id),
        .sprite_x  (sprite_x),
        .sprite_y  (sprite_y),
        .wrn       (wrn)
    );

    typedef struct packed {
        logic [7:0] id;
        logic [9:0] x;
        logic [8:0] y;
    } exp_t;

    exp_t exq[$];
    int   rises[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [7:0] id, input logic [9:0] d);
        exp_t e;
        e.id = id;
        e.x  = d;
        e.y  = d[8:0];
        exq.push_back(e);
    endtask

    task automatic push(input logic [7:0] id, input logic [9:0] d);
        cpu_we   = 1'b1;
        cpu_id   = id;
        cpu_data = d;
        @(posedge clk);
        #1;
        cpu_we   = 1'b0;
    endtask

    task automatic drain(input int maxc);
        logic done;
        done = 1'b0;
        for (int i = 0; i < maxc && !done; i++) begin
            @(negedge clk);
            if (exq.size() == 0 && pending == 4'd0 && wrn == 1'b1) done = 1'b1;
        end
        chk("drain_done", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every wrn rising edge is a write; data must match the head of
    // the expected queue both on the low cycle and after the edge.
    initial begin
        logic       prev_wrn;
        logic [7:0] prev_id;
        logic [9:0] prev_x;
        logic [8:0] prev_y;
        exp_t       e;
        prev_wrn = 1'b1;
        prev_id  = '0;
        prev_x   = '0;
        prev_y   = '0;
        forever begin
            @(negedge clk);
            if (prev_wrn === 1'b0 && wrn === 1'b1) begin
                rises.push_back(cyc);
                n_cmp++;
                if (exq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_write: got id=%0h x=%0h expected no write",
                             sprite_id, sprite_x);
                end else begin
                    e = exq.pop_front();
                    if (sprite_id !== e.id || sprite_x !== e.x || sprite_y !== e.y ||
                        prev_id !== e.id || prev_x !== e.x || prev_y !== e.y) begin
                        n_bad++;
                        $display("FAIL write_data: got id=%0h x=%0h y=%0h (low: %0h %0h %0h) expected id=%0h x=%0h y=%0h",
                                 sprite_id, sprite_x, sprite_y, prev_id, prev_x, prev_y,
                                 e.id, e.x, e.y);
                    end
                end
            end
            prev_wrn = wrn;
            prev_id  = sprite_id;
            prev_x   = sprite_x;
            prev_y   = sprite_y;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic low_seen;
        int   bad;
        rst = 1'b1; cpu_we = 1'b0; cpu_id = '0; cpu_data = '0;
        ovf_clr = 1'b0; vblank = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_wrn", {31'd0, wrn}, 32'd1);
        chk("rst_pending", {28'd0, pending}, 32'd0);
        chk("rst_ready", {31'd0, cpu_ready}, 32'd1);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_sprite_x", {22'd0, sprite_x}, 32'd0);
        @(posedge clk); #1;

        // Single write latency
        vblank = 1'b1;
        expect_wr(8'd4, 10'h140);
        push(8'd4, 10'h140);
        @(negedge clk);
        chk("t1_pending_n", {28'd0, pending}, 32'd1);
        chk("t1_wrn_n", {31'd0, wrn}, 32'd1);
        @(negedge clk);
        chk("t1_id_n1", {24'd0, sprite_id}, 32'd4);
        chk("t1_x_n1", {22'd0, sprite_x}, 32'h140);
        chk("t1_wrn_n1", {31'd0, wrn}, 32'd1);
        chk("t1_pending_n1", {28'd0, pending}, 32'd0);
        @(negedge clk);
        chk("t1_wrn_n2", {31'd0, wrn}, 32'd0);
        @(negedge clk);
        chk("t1_wrn_n3", {31'd0, wrn}, 32'd1);
        @(negedge clk);
        chk("t1_wrn_n4", {31'd0, wrn}, 32'd1);
        chk("t1_x_n4", {22'd0, sprite_x}, 32'h140);
        @(posedge clk); #1;

        // Six queued writes outside vblank, then replay
        vblank = 1'b0;
        for (int i = 0; i < 6; i++) begin
            expect_wr(8'(i), 10'h100 + 10'(i));
            push(8'(i), 10'h100 + 10'(i));
        end
        low_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (wrn !== 1'b1) low_seen = 1'b1;
        end
        chk("t2_no_wrn", {31'd0, low_seen}, 32'd0);
        chk("t2_pending", {28'd0, pending}, 32'd6);
        @(posedge clk); #1;
        rises.delete();
        vblank = 1'b1;
        drain(80);
        chk("t2_pulses", rises.size(), 32'd6);
        bad = 0;
        for (int i = 1; i < rises.size(); i++) if (rises[i] - rises[i-1] != 4) bad++;
        chk("t2_spacing", bad, 32'd0);
        vblank = 1'b0;

        // Overflow and ovf_clr priority
        for (int i = 0; i < 8; i++) begin
            expect_wr(8'(i), 10'h200 + 10'(i));
            push(8'(i), 10'h200 + 10'(i));
        end
        chk("t3_ready_full", {31'd0, cpu_ready}, 32'd0);
        chk("t3_ovf_before", {31'd0, ovf}, 32'd0);
        chk("t3_pending_full", {28'd0, pending}, 32'd8);
        push(8'h33, 10'h3FF);
        chk("t3_ovf_set", {31'd0, ovf}, 32'd1);
        chk("t3_pending_drop", {28'd0, pending}, 32'd8);
        ovf_clr = 1'b1;
        push(8'h34, 10'h3FE);
        ovf_clr = 1'b0;
        chk("t3_ovf_clr_wins", {31'd0, ovf}, 32'd0);
        vblank = 1'b1;
        drain(80);
        vblank = 1'b0;

        // vblank falls during LOW of the first entry
        for (int i = 0; i < 3; i++) begin
            expect_wr(8'h10 + 8'(i), 10'h3A0 + 10'(i));
            push(8'h10 + 8'(i), 10'h3A0 + 10'(i));
        end
        vblank = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t4_in_low", {31'd0, wrn}, 32'd0);
        vblank = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("t4_pending_wait", {28'd0, pending}, 32'd2);
        chk("t4_one_written", exq.size(), 32'd2);
        vblank = 1'b1;
        drain(80);
        vblank = 1'b0;

        // Reset while in LOW
        vblank = 1'b1;
        expect_wr(8'd2, 10'h0AA);
        push(8'd2, 10'h0AA);
        push(8'd3, 10'h055);
        @(posedge clk); #1;
        chk("t5_low", {31'd0, wrn}, 32'd0);
        chk("t5_pending_pre", {28'd0, pending}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_wrn_forced", {31'd0, wrn}, 32'd1);
        chk("t5_x_held", {22'd0, sprite_x}, 32'h0AA);
        @(posedge clk); #1;
        chk("t5_x_zero", {22'd0, sprite_x}, 32'd0);
        chk("t5_pending_zero", {28'd0, pending}, 32'd0);
        chk("t5_ready", {31'd0, cpu_ready}, 32'd1);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("t5_queue_empty", exq.size(), 32'd0);
        vblank = 1'b0;

        // Push coinciding with pop from full is rejected
        for (int i = 0; i < 8; i++) begin
            expect_wr(8'h20 + 8'(i), 10'h010 + 10'(i));
            push(8'h20 + 8'(i), 10'h010 + 10'(i));
        end
        chk("t6_pending_full", {28'd0, pending}, 32'd8);
        vblank   = 1'b1;
        cpu_we   = 1'b1;
        cpu_id   = 8'd9;
        cpu_data = 10'h3FF;
        @(posedge clk); #1;
        cpu_we = 1'b0;
        chk("t6_pending_7", {28'd0, pending}, 32'd7);
        chk("t6_ovf", {31'd0, ovf}, 32'd1);
        drain(80);
        vblank = 1'b0;

        chk("final_queue_empty", exq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
